// File: rtl/if_pc_gen_if.sv
// Fetch-stage bus bundle: stall/redirect inputs, decode-side PC bus and instruction SRAM request.
`default_nettype none

interface if_pc_gen_if;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  modport master (
    input  stall, br_bus,
    output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output stall, br_bus,
    input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );
endinterface

`default_nettype wire

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: owns the fetch PC, drives the instruction SRAM,
// and buffers decode redirects that land while the stage is stalled.
`default_nettype none

module if_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic         clk,
  input  logic         rst,
  if_pc_gen_if.master  bus
);

  typedef enum logic [0:0] {
    S_BOOT  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc_r;
  logic        ce_r;
  logic        br_pend;
  logic [31:0] br_pend_addr;

  logic        stop;
  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] next_pc;
  logic        unused_stall;

  assign stop            = bus.stall[0];
  assign {br_e, br_addr} = bus.br_bus;
  assign unused_stall    = ^bus.stall[5:1];

  // A live redirect beats a buffered one; the buffered one beats sequential flow.
  always_comb begin
    next_pc = pc_r + PC_STEP;
    if (br_e) begin
      next_pc = br_addr;
    end else if (br_pend) begin
      next_pc = br_pend_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r         <= RESET_PC - PC_STEP;
      ce_r         <= 1'b0;
      state        <= S_BOOT;
      br_pend      <= 1'b0;
      br_pend_addr <= 32'd0;
    end else begin
      case (state)
        S_BOOT: begin
          if (!stop) begin
            pc_r  <= RESET_PC;
            ce_r  <= 1'b1;
            state <= S_FETCH;
          end else begin
            ce_r  <= 1'b0;
          end
        end
        S_FETCH: begin
          if (!stop) begin
            pc_r    <= next_pc;
            br_pend <= 1'b0;
          end else if (br_e) begin
            // Latest redirect during a stall overwrites any earlier one.
            br_pend      <= 1'b1;
            br_pend_addr <= br_addr;
          end
        end
        default: begin
          state <= S_BOOT;
          ce_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_to_id_bus    = {ce_r, pc_r};
  assign bus.inst_sram_en    = ce_r;
  assign bus.inst_sram_addr  = pc_r;
  assign bus.inst_sram_wen   = 4'b0;
  assign bus.inst_sram_wdata = 32'b0;

endmodule

`default_nettype wire

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the architectural fetch PC and drives the synchronous-read instruction SRAM.
- Produces if_to_id_bus {ce, pc}. The instruction word returns on inst_sram_rdata one cycle later, when decode consumes it.
- Accepts redirects from decode on br_bus. A redirect that arrives while fetch is stalled is buffered, never dropped.

Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first instruction fetched after reset.
- PC_STEP, 32'd4, sequential PC increment.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting low clears all state immediately, without waiting for a clock edge.
- stall  input  `StallBus (6)  pipeline stall vector; stall[0]==`Stop freezes this stage.
- br_bus  input  `BR_WD (33)  {br_e, br_addr[31:0]} from decode.
- if_to_id_bus  output  `IF_TO_ID_WD (33)  {ce, pc[31:0]}.
- inst_sram_en  output  1  instruction SRAM enable.
- inst_sram_wen  output  4  byte write enables; always 4'b0.
- inst_sram_addr  output  32  fetch address.
- inst_sram_wdata  output  32  always 32'b0.

Behaviour:
- State registers: pc_r[31:0], ce_r, state ∈ {S_BOOT, S_FETCH}, br_pend, br_pend_addr[31:0].
- Reset (rst==0, asynchronous) sets:
  - pc_r = RESET_PC − PC_STEP (32'hBFBF_FFFC)
  - ce_r = 0
  - state = S_BOOT
  - br_pend = 0
  - br_pend_addr = 0
- Resulting output values during reset: if_to_id_bus = {1'b0, 32'hBFBF_FFFC}, inst_sram_en = 0, inst_sram_addr = 32'hBFBF_FFFC.
- Outputs are purely registered:
  - if_to_id_bus = {ce_r, pc_r}
  - inst_sram_en = ce_r
  - inst_sram_addr = pc_r
  - inst_sram_wen = 0
  - inst_sram_wdata = 0
- S_BOOT, on each edge:
  - If stall[0]==`NoStop: pc_r <= RESET_PC, ce_r <= 1, state <= S_FETCH.
  - If stall[0]==`Stop: remain in S_BOOT with ce_r = 0.
  - br_e is ignored in S_BOOT.
- S_FETCH, stall[0]==`NoStop: pc_r <= next_pc and br_pend <= 0. next_pc priority:
  1. br_e ? br_addr
  2. br_pend ? br_pend_addr
  3. pc_r + PC_STEP
- S_FETCH, stall[0]==`Stop:
  - pc_r and ce_r hold.
  - If br_e==1: br_pend <= 1 and br_pend_addr <= br_addr. The latest redirect wins if several arrive during one stall.
  - If br_e==0: br_pend and br_pend_addr hold.
- Latency:
  - A redirect seen in cycle N (no stall) appears as pc_r in cycle N+1.
  - Instruction data for pc_r in cycle N is valid on inst_sram_rdata in cycle N+1.
- Arithmetic: pc_r + PC_STEP is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. No alignment check is performed; br_addr is used verbatim.
- Simultaneous br_e and br_pend while not stalled: br_e wins and the pending entry is discarded.
- Stall release: the stall vector is owned by the hazard unit; this block only samples stall[0]. The first unstalled edge consumes br_pend.
- Reset mid-operation: all state is cleared immediately, the pending redirect is lost, and the S_BOOT sequence restarts after rst returns to 1.
- ce_r is 0 only in S_BOOT or during reset. Decode treats ce==0 as a bubble.

Test Plan:
1. Reset and boot: rst=0 for 3 cycles, then release with stall=0.
   - During reset: ce=0, pc=BFBF_FFFC.
   - First edge after release: ce=1, pc=BFC0_0000.
   - Next edges: pc=BFC0_0004, then BFC0_0008.
2. Taken branch with no stall: br_bus={1, 32'hBFC0_0100} for one cycle while pc=BFC0_0008.
   - Next pc=BFC0_0100, then BFC0_0104.
3. Branch during stall: stall[0]=1 for 3 cycles. br_e pulses with 32'hBFC0_0200 in stall cycle 1, then with 32'hBFC0_0300 in stall cycle 2.
   - pc holds for all 3 cycles.
   - First edge after release: pc=BFC0_0300.
   - br_pend then clears and pc increments to BFC0_0304.
4. Priority: create a pending redirect to 32'h0000_1000, then release stall in the same cycle that br_e presents 32'h0000_2000.
   - Next pc=0000_2000.
   - Next-next pc=0000_2004.
5. Wrap and reset mid-run:
   - Redirect to 32'hFFFF_FFFC, then no stall: next pc=0000_0000.
   - With br_pend=1, assert rst=0 asynchronously between clock edges: outputs go to {0, BFBF_FFFC} without waiting for an edge, and br_pend=0.
   - After release: boot sequence repeats exactly as in scenario 1.
6. Boot-stall: hold stall[0]=1 for 2 cycles after reset release.
   - ce stays 0 and pc stays BFBF_FFFC.
   - A br_e pulse during this time is ignored.
   - On release: pc=BFC0_0000.
